// File: rtl/router_rx_rtbuf_if.sv
// router_rx_rtbuf_if: input link and crossbar-side
// handshake signals of the replay receive buffer.
interface router_rx_rtbuf_if #(
  parameter int DW = 64
);
  logic          D_VALID;
  logic [DW-1:0] D;
  logic          D_BP;
  logic          Q_VALID;
  logic [DW-1:0] Q;
  logic          Q_BP;
  logic          COLLISION;

  modport slave (
    input  D_VALID, D, Q_BP, COLLISION,
    output D_BP, Q_VALID, Q
  );

  modport master (
    output D_VALID, D, Q_BP, COLLISION,
    input  D_BP, Q_VALID, Q
  );
endinterface

// File: rtl/router_rx_rtbuf.sv
// router_rx_rtbuf: rx FIFO plus backup of the packet in
// flight, replayed after a downstream collision.
module router_rx_rtbuf #(
  parameter int DW           = 64,
  parameter int FIFO_AW      = 9,
  parameter int AFULL_MARGIN = 16,
  parameter int BUP_AW       = 4,
  parameter int MAX_RETRY    = 3,
  localparam int RCW = $clog2(MAX_RETRY + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  router_rx_rtbuf_if.slave bus,
  output logic             RT_ACTIVE,
  output logic             RT_ERR,
  output logic             OVF,
  output logic [RCW-1:0]   RETRY_CNT
);

  localparam int FD = 1 << FIFO_AW;
  localparam int BD = 1 << BUP_AW;
  localparam int THR = FD - AFULL_MARGIN;
  localparam logic [FIFO_AW:0] FULL_OCC =
    (FIFO_AW + 1)'(FD);
  localparam logic [FIFO_AW:0] THR_OCC =
    (FIFO_AW + 1)'(THR);
  localparam logic [RCW-1:0] MAXR = RCW'(MAX_RETRY);

  typedef enum logic [1:0] {
    STREAM,
    HOLD,
    REPLAY
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]    mem [FD];
  logic [DW-1:0]    bup [BD];
  logic [FIFO_AW:0] wp, wp_d, rp, occ;
  logic [BUP_AW:0]  wa, rl;
  logic [BUP_AW-1:0] ra;
  logic [31:0]      togo;
  logic             bovf, col_q, d_bp;
  logic             full, fifo_rdy, src_valid;
  logic             q_valid, xfer, rd, col_rise;
  logic             is_hdr, single, eof;
  logic             refuse, last_rep;
  logic [DW-1:0]    q;

  assign occ       = wp - rp;
  assign full      = occ == FULL_OCC;
  // wp_d lags one edge so a new word shows a cycle late
  assign fifo_rdy  = wp_d != rp;
  assign src_valid = (state == REPLAY) ||
                     (state == STREAM && fifo_rdy);
  assign q_valid   = src_valid && !bus.Q_BP &&
                     !bus.COLLISION;
  assign xfer      = q_valid;
  assign rd        = q_valid && state == STREAM;
  assign q         = (state == REPLAY) ? bup[ra]
                   : mem[rp[FIFO_AW-1:0]];
  assign col_rise  = bus.COLLISION && !col_q;
  assign is_hdr    = togo == '0;
  assign single    = q[DW-1:DW-8] == 8'h01 ||
                     q[31:0] == '0;
  assign eof       = xfer &&
                     (is_hdr ? single : togo == 32'd1);
  assign refuse    = bovf || RETRY_CNT == MAXR;
  assign last_rep  = {1'b0, ra} == rl - 1'b1;

  assign bus.Q_VALID = q_valid;
  assign bus.Q       = q;
  assign bus.D_BP    = d_bp;
  assign RT_ACTIVE   = state == REPLAY;

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= STREAM;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      STREAM: begin
        if (col_rise && wa != '0) state_nx = HOLD;
      end
      HOLD: begin
        if (!bus.COLLISION)
          state_nx = refuse ? STREAM : REPLAY;
      end
      REPLAY: begin
        if (col_rise)              state_nx = HOLD;
        else if (xfer && last_rep) state_nx = STREAM;
      end
      default: state_nx = STREAM;
    endcase
  end

  // FIFO pointers, overflow flag and backpressure
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp   <= '0;
      wp_d <= '0;
      rp   <= '0;
      OVF  <= 1'b0;
      d_bp <= 1'b0;
    end else begin
      wp_d <= wp;
      d_bp <= occ >= THR_OCC;
      if (bus.D_VALID) begin
        if (full) OVF <= 1'b1;
        else      wp  <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (bus.D_VALID && !full)
      mem[wp[FIFO_AW-1:0]] <= bus.D;
  end

  // backup copy of streamed words
  always_ff @(posedge CLK) begin
    if (rd && !wa[BUP_AW])
      bup[wa[BUP_AW-1:0]] <= q;
  end

  // packet tracking, backup pointers and retry control
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_q     <= 1'b0;
      wa        <= '0;
      rl        <= '0;
      ra        <= '0;
      bovf      <= 1'b0;
      togo      <= '0;
      RETRY_CNT <= '0;
      RT_ERR    <= 1'b0;
    end else begin
      col_q  <= bus.COLLISION;
      RT_ERR <= 1'b0;
      if (xfer) begin
        if (state == REPLAY) ra <= ra + 1'b1;
        else if (!wa[BUP_AW]) wa <= wa + 1'b1;
        else bovf <= 1'b1;
        if (is_hdr) togo <= single ? '0 : q[31:0];
        else        togo <= togo - 32'd1;
      end
      if (eof) begin
        wa        <= '0;
        bovf      <= 1'b0;
        RETRY_CNT <= '0;
      end
      if (state != HOLD && state_nx == HOLD)
        togo <= '0;
      if (state == STREAM && state_nx == HOLD)
        rl <= wa;
      if (state == HOLD && !bus.COLLISION) begin
        if (refuse) begin
          RT_ERR    <= 1'b1;
          wa        <= '0;
          bovf      <= 1'b0;
          RETRY_CNT <= '0;
        end else begin
          RETRY_CNT <= RETRY_CNT + 1'b1;
          ra        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_rx_rtbuf.sv
// tb_router_rx_rtbuf: scoreboard bench for the replay
// receive buffer.
`timescale 1ns/1ps
module tb_router_rx_rtbuf;
  localparam int DW = 64;
  localparam int FIFO_AW = 9;
  localparam int AFULL_MARGIN = 16;
  localparam int BUP_AW = 4;
  localparam int MAX_RETRY = 3;
  localparam int FD = 1 << FIFO_AW;
  localparam int THR = FD - AFULL_MARGIN;
  localparam int RCW = $clog2(MAX_RETRY + 1);

  logic CLK = 1'b0;
  logic RST_N;
  logic RT_ACTIVE, RT_ERR, OVF;
  logic [RCW-1:0] RETRY_CNT;

  router_rx_rtbuf_if #(.DW(DW)) bus();

  router_rx_rtbuf #(
    .DW(DW), .FIFO_AW(FIFO_AW),
    .AFULL_MARGIN(AFULL_MARGIN),
    .BUP_AW(BUP_AW), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .RT_ACTIVE(RT_ACTIVE), .RT_ERR(RT_ERR),
    .OVF(OVF), .RETRY_CNT(RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];

  function automatic logic [DW-1:0] hdr(input int len);
    return {8'h02, 24'h0, 32'(len)};
  endfunction

  function automatic logic [DW-1:0] pw(input int t,
                                       input int i);
    return {8'hA5, 8'(t), 16'h0, 32'(i)};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.D_VALID = 1'b0;
    bus.D = '0;
    bus.Q_BP = 1'b0;
    bus.COLLISION = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    sb.delete();
    step();
  endtask

  task automatic preload(input logic [DW-1:0] w[$]);
    bus.Q_BP = 1'b1;
    foreach (w[i]) begin
      bus.D_VALID = 1'b1;
      bus.D = w[i];
      step();
    end
    bus.D_VALID = 1'b0;
    bus.D = '0;
  endtask

  task automatic test_reset();
    idle();
    RST_N = 1'b0;
    step();
    @(negedge CLK);
    checks += 6;
    if (bus.Q_VALID !== 1'b0) begin
      errs++; $display("FAIL rst_qvalid got %b exp 0", bus.Q_VALID);
    end
    if (bus.D_BP !== 1'b0) begin
      errs++; $display("FAIL rst_dbp got %b exp 0", bus.D_BP);
    end
    if (RT_ACTIVE !== 1'b0) begin
      errs++; $display("FAIL rst_rtactive got %b exp 0", RT_ACTIVE);
    end
    if (RT_ERR !== 1'b0) begin
      errs++; $display("FAIL rst_rterr got %b exp 0", RT_ERR);
    end
    if (OVF !== 1'b0) begin
      errs++; $display("FAIL rst_ovf got %b exp 0", OVF);
    end
    if (RETRY_CNT !== '0) begin
      errs++; $display("FAIL rst_retry got %0d exp 0", RETRY_CNT);
    end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] w[4];
    logic [DW-1:0] ex;
    int nx = 0, first = -1, act = 0, nerr = 0, rc = 0;
    bit colded = 0;
    do_reset();
    for (int i = 0; i < 4; i++)
      w[i] = {8'h01, 8'(i), 16'h0, 32'(100 + i)};
    for (int c = 0; c < 14; c++) begin
      bus.D_VALID = c < 4;
      bus.D = (c < 4) ? w[c] : '0;
      if (c < 4) sb.push_back(w[c]);
      bus.COLLISION = nx == 2 && !colded;
      if (nx == 2) colded = 1;
      @(negedge CLK);
      act += int'(RT_ACTIVE);
      nerr += int'(RT_ERR);
      if (RETRY_CNT != '0) rc++;
      if (bus.Q_VALID) begin
        if (first < 0) first = c;
        nx++;
        checks++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL single_q got %h exp none", bus.Q);
        end else begin
          ex = sb.pop_front();
          if (bus.Q !== ex) begin
            errs++; $display("FAIL single_q got %h exp %h", bus.Q, ex);
          end
        end
      end
      step();
    end
    bus.COLLISION = 1'b0;
    checks += 5;
    if (first != 2) begin
      errs++; $display("FAIL single_latency got %0d exp 2", first);
    end
    if (nx != 4) begin
      errs++; $display("FAIL single_count got %0d exp 4", nx);
    end
    if (act != 0) begin
      errs++; $display("FAIL single_rtactive got %0d exp 0", act);
    end
    if (nerr != 0) begin
      errs++; $display("FAIL single_rterr got %0d exp 0", nerr);
    end
    if (rc != 0) begin
      errs++; $display("FAIL single_retry got %0d exp 0", rc);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] w[$];
    logic [DW-1:0] ex;
    int nx = 0, cc = 0, act = 0, rc1 = 0;
    do_reset();
    w.push_back(hdr(5));
    for (int i = 1; i < 6; i++) w.push_back(pw(2, i));
    preload(w);
    for (int i = 0; i < 3; i++) sb.push_back(w[i]);
    for (int i = 0; i < 6; i++) sb.push_back(w[i]);
    bus.Q_BP = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.COLLISION = nx >= 3 && cc < 3;
      if (bus.COLLISION) cc++;
      @(negedge CLK);
      if (RT_ACTIVE) begin
        act++;
        if (RETRY_CNT == 1) rc1++;
      end
      if (bus.Q_VALID) begin
        nx++;
        checks++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL coll_q got %h exp none", bus.Q);
        end else begin
          ex = sb.pop_front();
          if (bus.Q !== ex) begin
            errs++; $display("FAIL coll_q got %h exp %h", bus.Q, ex);
          end
        end
      end
      step();
    end
    @(negedge CLK);
    checks += 4;
    if (nx != 9) begin
      errs++; $display("FAIL coll_count got %0d exp 9", nx);
    end
    if (act != 3) begin
      errs++; $display("FAIL coll_rtactive got %0d exp 3", act);
    end
    if (rc1 != 3) begin
      errs++; $display("FAIL coll_retry1 got %0d exp 3", rc1);
    end
    if (RETRY_CNT !== '0) begin
      errs++; $display("FAIL coll_retry_eof got %0d exp 0", RETRY_CNT);
    end
    step();
  endtask

  task automatic test_retry();
    logic [DW-1:0] w[$];
    logic [DW-1:0] ex;
    int seq[19] = '{0, 1, 0, 1, 2, 0, 1, 2, 3,
                    0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int trig[4] = '{2, 5, 9, 14};
    int nx = 0, k = 0, act = 0, nerr = 0, mx = 0;
    do_reset();
    w.push_back(hdr(9));
    for (int i = 1; i < 10; i++) w.push_back(pw(3, i));
    preload(w);
    foreach (seq[i]) sb.push_back(w[seq[i]]);
    bus.Q_BP = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.COLLISION = k < 4 && nx == trig[k & 3];
      if (bus.COLLISION) k++;
      @(negedge CLK);
      act += int'(RT_ACTIVE);
      nerr += int'(RT_ERR);
      if (int'(RETRY_CNT) > mx) mx = int'(RETRY_CNT);
      if (bus.Q_VALID) begin
        nx++;
        checks++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL retry_q got %h exp none", bus.Q);
        end else begin
          ex = sb.pop_front();
          if (bus.Q !== ex) begin
            errs++; $display("FAIL retry_q got %h exp %h", bus.Q, ex);
          end
        end
      end
      step();
    end
    @(negedge CLK);
    checks += 5;
    if (nx != 19) begin
      errs++; $display("FAIL retry_count got %0d exp 19", nx);
    end
    if (act != 9) begin
      errs++; $display("FAIL retry_rtactive got %0d exp 9", act);
    end
    if (nerr != 1) begin
      errs++; $display("FAIL retry_rterr got %0d exp 1", nerr);
    end
    if (mx != MAX_RETRY) begin
      errs++; $display("FAIL retry_max got %0d exp %0d", mx, MAX_RETRY);
    end
    if (RETRY_CNT !== '0) begin
      errs++; $display("FAIL retry_clear got %0d exp 0", RETRY_CNT);
    end
    step();
  endtask

  task automatic test_bovf();
    logic [DW-1:0] w[$];
    logic [DW-1:0] ex;
    int nx = 0, act = 0, nerr = 0;
    bit colded = 0;
    do_reset();
    w.push_back(hdr(19));
    for (int i = 1; i < 20; i++) w.push_back(pw(4, i));
    preload(w);
    foreach (w[i]) sb.push_back(w[i]);
    bus.Q_BP = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.COLLISION = nx == 19 && !colded;
      if (bus.COLLISION) colded = 1;
      @(negedge CLK);
      act += int'(RT_ACTIVE);
      nerr += int'(RT_ERR);
      if (bus.Q_VALID) begin
        nx++;
        checks++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL bovf_q got %h exp none", bus.Q);
        end else begin
          ex = sb.pop_front();
          if (bus.Q !== ex) begin
            errs++; $display("FAIL bovf_q got %h exp %h", bus.Q, ex);
          end
        end
      end
      step();
    end
    bus.COLLISION = 1'b0;
    checks += 3;
    if (nx != 20) begin
      errs++; $display("FAIL bovf_count got %0d exp 20", nx);
    end
    if (act != 0) begin
      errs++; $display("FAIL bovf_rtactive got %0d exp 0", act);
    end
    if (nerr != 1) begin
      errs++; $display("FAIL bovf_rterr got %0d exp 1", nerr);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ex;
    int nx = 0, occ;
    bit bp_ex, ovf_ex;
    do_reset();
    bus.Q_BP = 1'b1;
    for (int k = 1; k <= FD + 2; k++) begin
      bus.D_VALID = 1'b1;
      bus.D = {8'h01, 24'(k), 32'(k)};
      if (k <= FD) sb.push_back(bus.D);
      step();
      occ = (k - 1 < FD) ? k - 1 : FD;
      bp_ex = occ >= THR;
      ovf_ex = k > FD;
      checks += 2;
      if (bus.D_BP !== bp_ex) begin
        errs++; $display("FAIL bp_dbp k=%0d got %b exp %b", k, bus.D_BP, bp_ex);
      end
      if (OVF !== ovf_ex) begin
        errs++; $display("FAIL bp_ovf k=%0d got %b exp %b", k, OVF, ovf_ex);
      end
    end
    bus.D_VALID = 1'b0;
    bus.D = '0;
    bus.Q_BP = 1'b0;
    for (int c = 0; c < FD + 10; c++) begin
      @(negedge CLK);
      if (bus.Q_VALID) begin
        nx++;
        checks++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL bp_q got %h exp none", bus.Q);
        end else begin
          ex = sb.pop_front();
          if (bus.Q !== ex) begin
            errs++; $display("FAIL bp_q got %h exp %h", bus.Q, ex);
          end
        end
      end
      step();
    end
    checks += 3;
    if (nx != FD) begin
      errs++; $display("FAIL bp_count got %0d exp %0d", nx, FD);
    end
    if (OVF !== 1'b1) begin
      errs++; $display("FAIL bp_ovf_sticky got %b exp 1", OVF);
    end
    if (bus.D_BP !== 1'b0) begin
      errs++; $display("FAIL bp_release got %b exp 0", bus.D_BP);
    end
  endtask

  task automatic test_reset_replay();
    logic [DW-1:0] w[$];
    logic [DW-1:0] ex;
    int nx = 0, cc = 0;
    bit found = 0;
    do_reset();
    w.push_back(hdr(5));
    for (int i = 1; i < 6; i++) w.push_back(pw(5, i));
    preload(w);
    for (int i = 0; i < 3; i++) sb.push_back(w[i]);
    bus.Q_BP = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      bus.COLLISION = nx >= 3 && cc < 1;
      if (bus.COLLISION) cc++;
      @(negedge CLK);
      if (RT_ACTIVE) begin
        found = 1;
      end else begin
        if (bus.Q_VALID) begin
          nx++;
          checks++;
          if (sb.size() == 0) begin
            errs++; $display("FAIL rrst_q got %h exp none", bus.Q);
          end else begin
            ex = sb.pop_front();
            if (bus.Q !== ex) begin
              errs++; $display("FAIL rrst_q got %h exp %h", bus.Q, ex);
            end
          end
        end
        step();
      end
    end
    checks++;
    if (!found) begin
      errs++; $display("FAIL rrst_timeout got no replay exp replay");
    end
    bus.COLLISION = 1'b0;
    RST_N = 1'b0;
    #1;
    checks += 4;
    if (bus.Q_VALID !== 1'b0) begin
      errs++; $display("FAIL rrst_qvalid got %b exp 0", bus.Q_VALID);
    end
    if (RT_ACTIVE !== 1'b0) begin
      errs++; $display("FAIL rrst_rtactive got %b exp 0", RT_ACTIVE);
    end
    if (RETRY_CNT !== '0) begin
      errs++; $display("FAIL rrst_retry got %0d exp 0", RETRY_CNT);
    end
    if (RT_ERR !== 1'b0) begin
      errs++; $display("FAIL rrst_rterr got %b exp 0", RT_ERR);
    end
    step();
    RST_N = 1'b1;
    sb.delete();
    step();
    @(negedge CLK);
    checks++;
    if (bus.Q_VALID !== 1'b0) begin
      errs++; $display("FAIL rrst_empty got %b exp 0", bus.Q_VALID);
    end
    step();
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    test_reset();
    test_single();
    test_collision();
    test_retry();
    test_bovf();
    test_backpressure();
    test_reset_replay();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
